// File: rtl/window_generator.sv
// window_generator
//   Streaming F x F sliding-window generator. Pixels arrive in raster order;
//   each accepted pixel whose position completes a full in-row window loads
//   out_data with that window (bottom-right tap = the pixel just accepted).
//
//   Optional build macro: WINDOW_GEN_STRIDE2_EN
//     defined   -> only windows whose top-left tap has even row and even col
//     undefined -> every valid window position is emitted (stride 1)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   clk_en      global enable; when low every register holds
//   in_valid    in_data carries a pixel
//   in_ready    block can accept a pixel (combinational from out_ready)
//   in_data     pixel, channel k at [k*D_WIDTH +: D_WIDTH]
//   out_valid   out_data holds a complete window
//   out_ready   consumer accepts the window
//   out_data    window, tap (r,c) channel k at [((r*F+c)*C+k)*D_WIDTH +: D_WIDTH]
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
//
// States
//   ST_IDLE   | no pixel of the current frame accepted yet
//   ST_FILL   | filling the first F-1 rows, no window possible
//   ST_STREAM | rows F-1..H-1, windows emitted

module window_generator #(
  parameter int FILTER_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28,
  parameter int D_WIDTH      = 8,
  parameter int CHANNELS     = 1
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  clk_en,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic [D_WIDTH*CHANNELS-1:0]                           in_data,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [D_WIDTH*CHANNELS*FILTER_SIZE*FILTER_SIZE-1:0]   out_data,
  output logic                                                  frame_done
);

  localparam int F        = FILTER_SIZE;
  localparam int W        = IMAGE_WIDTH;
  localparam int H        = IMAGE_HEIGHT;
  localparam int PW       = D_WIDTH * CHANNELS;
  localparam int OW       = PW * F * F;
  // Each line buffer plus the F-1 taps of the row below it delays a pixel
  // by exactly W accepts, i.e. one row.
  localparam int LB_DEPTH = W - F + 1;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int CW       = $clog2(W);
  localparam int RW       = $clog2(H);

  localparam logic [CW-1:0] COL_LAST  = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(F - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(F - 1);
  localparam logic [RW-1:0] ROW_FILL  = RW'(F - 2);
  localparam logic [AW-1:0] ADDR_LAST = AW'(LB_DEPTH - 1);
  // Parity of the bottom-right coordinate when the top-left one is even.
  localparam logic          FM1_ODD   = 1'((F - 1) % 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            out_valid_q, out_valid_d;
  logic [OW-1:0]   out_data_q, out_data_d;
  logic            frame_done_q, frame_done_d;

  // taps_q[r][0] is the leftmost (oldest) column held for window row r.
  logic [PW-1:0]   taps_q [F][F-1];
  logic [PW-1:0]   taps_d [F][F-1];
  logic [PW-1:0]   lb_mem [F-1][LB_DEPTH];

  logic [PW-1:0]   new_col [F];
  logic [OW-1:0]   win;
  logic            acc;
  logic            col_last;
  logic            row_last;
  logic            emit;

  assign in_ready   = !out_valid_q || out_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

  always_comb begin
    acc      = clk_en && in_valid && in_ready;
    col_last = (col_q == COL_LAST);
    row_last = (row_q == ROW_LAST);

    for (int r = 0; r < F - 1; r++) begin
      new_col[r] = lb_mem[r][addr_q];
    end
    new_col[F-1] = in_data;

    win = '0;
    for (int r = 0; r < F; r++) begin
      for (int c = 0; c < F - 1; c++) begin
        win[(r*F+c)*PW +: PW] = taps_q[r][c];
      end
      win[(r*F+F-1)*PW +: PW] = new_col[r];
    end

    emit = acc && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
`ifdef WINDOW_GEN_STRIDE2_EN
    emit = emit && (row_q[0] == FM1_ODD) && (col_q[0] == FM1_ODD);
`endif

    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    addr_d       = addr_q;
    taps_d       = taps_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = frame_done_q;

    if (acc) begin
      for (int r = 0; r < F; r++) begin
        for (int c = 0; c < F - 2; c++) begin
          taps_d[r][c] = taps_q[r][c+1];
        end
        taps_d[r][F-2] = new_col[r];
      end

      addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + AW'(1);

      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_FILL;
          if (row_q == ROW_FILL && col_last) state_d = ST_STREAM;
        end
        ST_FILL: begin
          if (row_q == ROW_FILL && col_last) state_d = ST_STREAM;
        end
        ST_STREAM: begin
          if (row_last && col_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // frame_done is a pulse only while enabled; a disabled cycle holds it.
    if (clk_en) begin
      frame_done_d = acc && (state_q == ST_STREAM) && row_last && col_last;
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = win;
    end else if (clk_en && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < F; r++) begin
        for (int c = 0; c < F - 1; c++) begin
          taps_q[r][c] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      taps_q       <= taps_d;
    end
  end

  // Line buffers are not reset; FILL always rewrites F-1 rows before use.
  // Read-before-write at a shared address gives exactly LB_DEPTH of delay.
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int r = 0; r < F - 1; r++) begin
        lb_mem[r][addr_q] <= taps_q[r+1][0];
      end
    end
  end

endmodule

// File: tb/tb_window_generator.sv
module tb_window_generator;

  localparam int F  = 3;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int DW = 8;
  localparam int OW = DW * F * F;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          frame_done;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  window_generator #(
    .FILTER_SIZE (F),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .D_WIDTH     (DW),
    .CHANNELS    (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .frame_done(frame_done)
  );

  function automatic logic [OW-1:0] win_of(input int base, input int br_r, input int br_c);
    logic [OW-1:0] w;
    w = '0;
    for (int r = 0; r < F; r++)
      for (int c = 0; c < F; c++)
        w[(r*F+c)*DW +: DW] = DW'(base + W*(br_r-F+1+r) + (br_c-F+1+c));
    return w;
  endfunction

  function automatic bit emits(input int r, input int c);
    bit e;
    e = (r >= F-1) && (c >= F-1);
`ifdef WINDOW_GEN_STRIDE2_EN
    e = e && ((r-F+1) % 2 == 0) && ((c-F+1) % 2 == 0);
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: a window is consumed when the edge sees valid, ready and enable.
  always @(negedge clk) begin
    if (out_valid && out_ready && clk_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_window: got %0h expected none", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_window", out_data, e.data);
        check("sb_frame_done", OW'(frame_done), OW'(e.last));
      end
    end
  end

  task automatic push_frame(input int base, input int n_pix);
    int last_idx;
    last_idx = W*H - 1;
    for (int i = 0; i < n_pix; i++) begin
      if (emits(i / W, i % W)) begin
        exp_t e;
        e.data = win_of(base, i / W, i % W);
        e.last = (i == last_idx);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called right after a posedge (#1); returns at the same phase.
  task automatic send_frame(input int base, input bit rnd, input bit stall, input int n_pix);
    int  idx;
    int  cyc;
    bit  en, v, accepted;
    idx = 0;
    cyc = 0;
    push_frame(base, n_pix);
    while (idx < n_pix) begin
      en = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      v  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      clk_en    = en;
      in_valid  = v;
      in_data   = DW'(base + idx);
      out_ready = 1'b1;
      @(negedge clk);
      accepted = v && en && in_ready;
      @(posedge clk);
      #1;
      if (accepted) begin
        check("latency_valid", OW'(out_valid), OW'(emits(idx / W, idx % W)));
        if (emits(idx / W, idx % W))
          check("latency_data", out_data, win_of(base, idx / W, idx % W));
        idx++;
`ifndef WINDOW_GEN_STRIDE2_EN
        if (stall && idx == 2*W + 4) begin
          clk_en    = 1'b1;
          in_valid  = 1'b1;
          in_data   = DW'(base + idx);
          out_ready = 1'b0;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", OW'(in_ready), OW'(0));
            check("stall_out_valid", OW'(out_valid), OW'(1));
            check("stall_out_data", out_data, win_of(base, 2, 3));
            @(posedge clk);
            #1;
          end
          out_ready = 1'b1;
        end
`endif
      end
      cyc++;
      if (cyc > 2000) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: got %0d pixels expected %0d", idx, n_pix);
        break;
      end
    end
    in_valid = 1'b0;
    clk_en   = 1'b1;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    in_valid  = 1'b0;
    clk_en    = 1'b1;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_empty", OW'(exp_q.size()), OW'(0));
  endtask

  initial begin
    reset     = 1'b1;
    clk_en    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", OW'(out_valid), OW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_frame_done", OW'(frame_done), OW'(0));
    check("rst_in_ready", OW'(in_ready), OW'(1));

    send_frame(0, 1'b0, 1'b0, W*H);
    send_frame(100, 1'b0, 1'b0, W*H);
    drain();

    send_frame(0, 1'b0, 1'b1, W*H);
    drain();

    send_frame(0, 1'b1, 1'b0, W*H);
    drain();

    // Abort after pixel 13; its window is taken in the reset cycle.
    send_frame(0, 1'b0, 1'b0, 2*W + 4);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_mid_valid", OW'(out_valid), OW'(0));
    check("reset_mid_queue", OW'(exp_q.size()), OW'(0));
    send_frame(0, 1'b0, 1'b0, W*H);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
